// File: rtl/frame_buf_writer.sv
// rtl/frame_buf_writer.sv - RGB888 pixel stream to RGB565 frame RAM write port
// Ports: iClk/iRsn clock and asynchronous active-low reset; iEnable arms capture;
//        iValid/oReady/iData/iSof/iEol pixel stream in; oRamWrEn/oRamWrAddr/
//        oRamWrData frame RAM write port (raster order); oFrameDone one-cycle
//        end-of-frame pulse; oLineErr sticky malformed-frame flag.
module frame_buf_writer #(
    parameter int H_ACTIVE = 480,
    parameter int V_ACTIVE = 272
) (
    input  logic        iClk,
    input  logic        iRsn,
    input  logic        iEnable,
    input  logic        iValid,
    input  logic [23:0] iData,
    input  logic        iSof,
    input  logic        iEol,
    output logic        oReady,
    output logic        oRamWrEn,
    output logic [16:0] oRamWrAddr,
    output logic [15:0] oRamWrData,
    output logic        oFrameDone,
    output logic        oLineErr
);
    // x needs one extra code point: H_ACTIVE marks a line that has overflowed
    localparam int X_W = $clog2(H_ACTIVE + 1);
    localparam int Y_W = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam logic [X_W-1:0] X_FULL   = X_W'(H_ACTIVE);
    localparam logic [X_W-1:0] X_LAST   = X_W'(H_ACTIVE - 1);
    localparam logic [Y_W-1:0] Y_LAST   = Y_W'(V_ACTIVE - 1);
    localparam logic [16:0]    ROW_STEP = 17'(H_ACTIVE);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SOF,
        ACTIVE,
        DONE
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [16:0]    rb;

    logic accept;
    logic overflow;
    logic line_end;
    logic last_line;
    logic do_write;

    assign oReady     = (state == WAIT_SOF) || (state == ACTIVE);
    assign oFrameDone = (state == DONE);
    assign accept     = iValid && oReady;
    assign overflow   = (x == X_FULL);
    assign last_line  = (y == Y_LAST);
    // An SOF beat restarts the frame, so it never counts as a line end
    assign line_end   = accept && (state == ACTIVE) && !iSof && iEol;
    assign do_write   = accept && (iSof || ((state == ACTIVE) && !overflow));

    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (iEnable) begin
                    state_nxt = WAIT_SOF;
                end
            end
            WAIT_SOF: begin
                if (accept && iSof) begin
                    state_nxt = ACTIVE;
                end else if (!iEnable && !accept) begin
                    state_nxt = IDLE;
                end
            end
            ACTIVE: begin
                if (line_end && last_line) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = iEnable ? WAIT_SOF : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Position counters; rb tracks y*H_ACTIVE by accumulation
    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            x  <= '0;
            y  <= '0;
            rb <= '0;
        end else if (accept && iSof) begin
            x  <= X_W'(1);
            y  <= '0;
            rb <= '0;
        end else if (line_end) begin
            x <= '0;
            if (last_line) begin
                y  <= '0;
                rb <= '0;
            end else begin
                y  <= y + 1'b1;
                rb <= rb + ROW_STEP;
            end
        end else if (accept && (state == ACTIVE) && !overflow) begin
            x <= x + 1'b1;
        end
    end

    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            oRamWrEn   <= 1'b0;
            oRamWrAddr <= '0;
            oRamWrData <= '0;
            oLineErr   <= 1'b0;
        end else begin
            oRamWrEn <= do_write;
            if (do_write) begin
                oRamWrAddr <= iSof ? 17'd0 : (rb + 17'(x));
                oRamWrData <= {iData[23:19], iData[15:10], iData[7:3]};
            end
            // x != X_LAST on an EOL covers both short lines and the
            // discarded EOL that closes an overflowed line
            if (accept && iSof && (state == WAIT_SOF)) begin
                oLineErr <= 1'b0;
            end else if (accept && (state == ACTIVE) &&
                         (iSof || overflow || (iEol && (x != X_LAST)))) begin
                oLineErr <= 1'b1;
            end
        end
    end

endmodule
